// File: rtl/wb_io_la_bridge_pkg.sv
// Shared definitions for the Wishbone GPIO bridge: register map, window size,
// bus FSM states and LO/HI word helpers.
package wb_io_pkg;

  localparam int unsigned WINDOW_BYTES = 256;
  localparam int unsigned WIN_BITS     = $clog2(WINDOW_BYTES);

  // Register index = byte offset / 8; each register owns a LO and a HI word.
  localparam logic [4:0] REG_OUT      = 5'd0;
  localparam logic [4:0] REG_OEB      = 5'd1;
  localparam logic [4:0] REG_IN       = 5'd2;
  localparam logic [4:0] REG_IRQ_EN   = 5'd3;
  localparam logic [4:0] REG_IRQ_STAT = 5'd4;
  localparam logic [4:0] REG_SEL      = 5'd5;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_e;

  function automatic logic [4:0] reg_index(input logic [5:0] word_adr);
    return word_adr[5:1];
  endfunction

  function automatic logic is_hi_word(input logic [5:0] word_adr);
    return word_adr[0];
  endfunction

  // 64-bit byte-lane mask for a 32-bit write landing in the LO or HI word.
  function automatic logic [63:0] lane_mask(input logic hi, input logic [3:0] sel);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) m[{hi, b[1:0], 3'b000} +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_io_la_bridge_io_sync_edge.sv
// Pad input synchroniser with a one-cycle-delayed copy and a registered
// rising-edge pulse per bit.
module io_sync_edge #(
  parameter int W      = 38,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] sync_d_q;
  logic [W-1:0] rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) chain_q[s] <= '0;
      sync_d_q <= '0;
      rise_q   <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) chain_q[s] <= chain_q[s-1];
      sync_d_q <= chain_q[STAGES-1];
      // Edge pulse is registered so the status logic never sees the sync chain directly.
      rise_q   <= chain_q[STAGES-1] & ~sync_d_q;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/wb_io_la_bridge.sv
// Wishbone slave register bank owning the user GPIO pads: per-pin core/software
// pad mux, synchronised inputs and rising-edge interrupts folded onto user_irq.
module wb_io_la_bridge
  import wb_io_pkg::*;
#(
  parameter int unsigned NUM_IO      = 38,
  parameter int unsigned NUM_IRQ     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [NUM_IO-1:0]  io_in,
  output logic [NUM_IO-1:0]  io_out,
  output logic [NUM_IO-1:0]  io_oeb,
  input  logic [NUM_IO-1:0]  core_io_out,
  input  logic [NUM_IO-1:0]  core_io_oeb,
  output logic [NUM_IO-1:0]  core_io_in,
  output logic [NUM_IRQ-1:0] user_irq
);

  wb_state_e          state_q, state_d;
  logic [31:0]        dat_q, dat_d;
  logic [NUM_IO-1:0]  out_q, out_d, oeb_q, oeb_d, en_q, en_d;
  logic [NUM_IO-1:0]  stat_q, stat_d, sel_q, sel_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;

  logic [NUM_IO-1:0]  sync, rise;
  logic               req, wr_en, hi;
  logic [5:0]         word_adr;
  logic [4:0]         idx;
  logic [63:0]        wmask64, wval64, rd64;
  logic [NUM_IO-1:0]  wmask, wval, clr;
  logic [31:0]        rdata;
  logic               unused_ok;

  io_sync_edge #(
    .W      (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (io_in),
    .sync_o (sync),
    .rise_o (rise)
  );

  assign core_io_in = sync;

  // Address decode; byte offset bits 1:0 are ignored (word accesses only).
  assign req      = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign word_adr = wbs_adr_i[7:2];
  assign idx      = reg_index(word_adr);
  assign hi       = is_hi_word(word_adr);
  assign wmask64  = lane_mask(hi, wbs_sel_i);
  assign wval64   = {wbs_dat_i, wbs_dat_i};
  assign wmask    = wmask64[NUM_IO-1:0];
  assign wval     = wval64[NUM_IO-1:0];
  assign unused_ok = ^{wbs_adr_i[1:0], wmask64, wval64};

  // Writes commit on the edge that closes the ack cycle.
  assign wr_en = (state_q == WB_ACK) & req & wbs_we_i;

  always_comb begin
    rd64 = '0;
    case (idx)
      REG_OUT:      rd64[NUM_IO-1:0] = out_q;
      REG_OEB:      rd64[NUM_IO-1:0] = oeb_q;
      REG_IN:       rd64[NUM_IO-1:0] = sync;
      REG_IRQ_EN:   rd64[NUM_IO-1:0] = en_q;
      REG_IRQ_STAT: rd64[NUM_IO-1:0] = stat_q;
      REG_SEL:      rd64[NUM_IO-1:0] = sel_q;
      default:      rd64 = '0;
    endcase
    rdata = hi ? rd64[63:32] : rd64[31:0];
  end

  always_comb begin
    state_d = state_q;
    dat_d   = '0;
    case (state_q)
      WB_IDLE: begin
        if (req) begin
          state_d = WB_ACK;
          dat_d   = rdata;
        end
      end
      WB_ACK:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    oeb_d = oeb_q;
    en_d  = en_q;
    sel_d = sel_q;
    clr   = '0;
    if (wr_en) begin
      case (idx)
        REG_OUT:      out_d = (out_q & ~wmask) | (wval & wmask);
        REG_OEB:      oeb_d = (oeb_q & ~wmask) | (wval & wmask);
        REG_IRQ_EN:   en_d  = (en_q  & ~wmask) | (wval & wmask);
        REG_IRQ_STAT: clr   = wval & wmask;
        REG_SEL:      sel_d = (sel_q & ~wmask) | (wval & wmask);
        default:      ;
      endcase
    end
    // A new edge in the same cycle as a clear keeps the bit set.
    stat_d = (stat_q & ~clr) | (rise & en_q);
  end

  always_comb begin
    irq_d = '0;
    for (int i = 0; i < int'(NUM_IO); i++) begin
      if (stat_q[i] & en_q[i]) irq_d[i % NUM_IRQ] = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= WB_IDLE;
      dat_q   <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      en_q    <= '0;
      stat_q  <= '0;
      sel_q   <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      sel_q   <= sel_d;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o = (state_q == WB_ACK);
  assign wbs_dat_o = dat_q;
  assign user_irq  = irq_q;
  assign io_out    = (sel_q & core_io_out) | (~sel_q & out_q);
  assign io_oeb    = (sel_q & core_io_oeb) | (~sel_q & oeb_q);

endmodule
